// File: rtl/mmu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmu_pkg : shared FSM state encoding and default operand geometry      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package mmu_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_LENGTH = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } mmu_state_t;

endpackage
`default_nettype wire

// File: rtl/mmu_skew_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmu_skew_mux : picks the diagonal element of one operand bank for a   |
// | feed step (lane r gets index k = step - r - 1). Rev 1.0               |
// +----------------------------------------------------------------------+
module mmu_skew_mux
    import mmu_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LENGTH    = DEFAULT_LENGTH,
    parameter int STEP_W    = $clog2(2 * DEFAULT_LENGTH),
    parameter bit TRANSPOSE = 1'b0
) (
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  mat   [0:LENGTH-1][0:LENGTH-1],
    output logic [WIDTH-1:0]  lanes [0:LENGTH-1]
);

    // A lanes walk along a row, B lanes walk down a column.
    always_comb begin
        for (int r = 0; r < LENGTH; r++) begin
            lanes[r] = '0;
            for (int k = 0; k < LENGTH; k++) begin
                if (int'(step) == r + k + 1) begin
                    lanes[r] = TRANSPOSE ? mat[k][r] : mat[r][k];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmu_feed_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmu_feed_controller : operand buffers and skewed feed sequencer for a |
// | LENGTH x LENGTH systolic array. Option macro: MMU_FEED_AUTO_CLEAR_EN  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module mmu_feed_controller
    import mmu_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int LENGTH = DEFAULT_LENGTH
) (
    input  logic                       CLK,
    input  logic                       ASYNC_RST,
    input  logic                       start,
    input  logic                       load_en,
    input  logic                       load_sel,
    input  logic [$clog2(LENGTH)-1:0]  load_row,
    input  logic [$clog2(LENGTH)-1:0]  load_col,
    input  logic [WIDTH-1:0]           load_data,
    output logic                       load_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       mmu_en,
    output logic                       mmu_sync_rst,
    output logic [WIDTH-1:0]           mmu_inputs  [0:LENGTH-1],
    output logic [WIDTH-1:0]           mmu_weights [0:LENGTH-1]
);

    localparam int                STEP_W     = $clog2(2 * LENGTH);
    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(2 * LENGTH - 1);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(LENGTH);

    mmu_state_t        state, next_state;
    logic [STEP_W-1:0] step, next_step;
    logic [WIDTH-1:0]  a_buf  [0:LENGTH-1][0:LENGTH-1];
    logic [WIDTH-1:0]  b_buf  [0:LENGTH-1][0:LENGTH-1];
    logic [WIDTH-1:0]  a_next [0:LENGTH-1][0:LENGTH-1];
    logic [WIDTH-1:0]  b_next [0:LENGTH-1][0:LENGTH-1];
    logic [WIDTH-1:0]  a_lanes [0:LENGTH-1];
    logic [WIDTH-1:0]  b_lanes [0:LENGTH-1];
    logic              accept_load;

    assign accept_load = load_en && (state == ST_IDLE);

    // The skew muxes see the post-write buffers so a load coinciding with
    // start already feeds its new value on the first step.
    always_comb begin
        a_next = a_buf;
        b_next = b_buf;
        if (accept_load && (int'(load_row) < LENGTH) && (int'(load_col) < LENGTH)) begin
            if (load_sel) b_next[load_row][load_col] = load_data;
            else          a_next[load_row][load_col] = load_data;
        end
    end

    always_comb begin
        next_state = state;
        next_step  = step;
        case (state)
            ST_IDLE: begin
                next_step = '0;
                if (start) begin
`ifdef MMU_FEED_AUTO_CLEAR_EN
                    next_state = ST_CLEAR;
`else
                    next_state = ST_FEED;
                    next_step  = STEP_W'(1);
`endif
                end
            end
            ST_CLEAR: begin
                next_state = ST_FEED;
                next_step  = STEP_W'(1);
            end
            ST_FEED: begin
                if (step == FEED_LAST) begin
                    next_state = ST_DRAIN;
                    next_step  = STEP_W'(1);
                end else begin
                    next_step = step + STEP_W'(1);
                end
            end
            ST_DRAIN: begin
                if (step == DRAIN_LAST) begin
                    next_state = ST_DONE;
                    next_step  = '0;
                end else begin
                    next_step = step + STEP_W'(1);
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
                next_step  = '0;
            end
            default: begin
                next_state = ST_IDLE;
                next_step  = '0;
            end
        endcase
    end

    mmu_skew_mux #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .STEP_W(STEP_W), .TRANSPOSE(1'b0)
    ) u_skew_a (
        .step(next_step), .mat(a_next), .lanes(a_lanes)
    );

    mmu_skew_mux #(
        .WIDTH(WIDTH), .LENGTH(LENGTH), .STEP_W(STEP_W), .TRANSPOSE(1'b1)
    ) u_skew_b (
        .step(next_step), .mat(b_next), .lanes(b_lanes)
    );

    // Outputs are registered from the next-state view so they line up with state.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state      <= ST_IDLE;
            step       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mmu_en     <= 1'b0;
            load_ready <= 1'b1;
            for (int r = 0; r < LENGTH; r++) begin
                mmu_inputs[r]  <= '0;
                mmu_weights[r] <= '0;
                for (int c = 0; c < LENGTH; c++) begin
                    a_buf[r][c] <= '0;
                    b_buf[r][c] <= '0;
                end
            end
        end else begin
            state      <= next_state;
            step       <= next_step;
            a_buf      <= a_next;
            b_buf      <= b_next;
            busy       <= (next_state != ST_IDLE);
            done       <= (next_state == ST_DONE);
            mmu_en     <= (next_state == ST_FEED) || (next_state == ST_DRAIN);
            load_ready <= (next_state == ST_IDLE);
            for (int r = 0; r < LENGTH; r++) begin
                mmu_inputs[r]  <= (next_state == ST_FEED) ? a_lanes[r] : '0;
                mmu_weights[r] <= (next_state == ST_FEED) ? b_lanes[r] : '0;
            end
        end
    end

`ifdef MMU_FEED_AUTO_CLEAR_EN
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) mmu_sync_rst <= 1'b0;
        else            mmu_sync_rst <= (next_state == ST_CLEAR);
    end
`else
    assign mmu_sync_rst = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmu_feed_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmu_feed_controller : scoreboard bench with a behavioural          |
// | output-stationary systolic array attached. Rev 1.0                    |
// +----------------------------------------------------------------------+
module tb_mmu_feed_controller;

    localparam int W  = 8;
    localparam int L  = 3;
    localparam int VW = 2 * L * W;
`ifdef MMU_FEED_AUTO_CLEAR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         CLK, ASYNC_RST, start, load_en, load_sel;
    logic [1:0]   load_row, load_col;
    logic [W-1:0] load_data;
    logic         load_ready, busy, done, mmu_en, mmu_sync_rst;
    logic [W-1:0] mmu_inputs  [0:L-1];
    logic [W-1:0] mmu_weights [0:L-1];

    mmu_feed_controller #(.WIDTH(W), .LENGTH(L)) dut (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .start(start), .load_en(load_en),
        .load_sel(load_sel), .load_row(load_row), .load_col(load_col),
        .load_data(load_data), .load_ready(load_ready), .busy(busy), .done(done),
        .mmu_en(mmu_en), .mmu_sync_rst(mmu_sync_rst),
        .mmu_inputs(mmu_inputs), .mmu_weights(mmu_weights)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural array: A flows right, B flows down, each PE accumulates.
    logic [31:0]  acc [0:L-1][0:L-1];
    logic [W-1:0] ap  [0:L-1][0:L-1];
    logic [W-1:0] bp  [0:L-1][0:L-1];

    function automatic logic [W-1:0] a_in(int i, int j);
        return (j == 0) ? mmu_inputs[i] : ap[i][(j > 0) ? j - 1 : 0];
    endfunction
    function automatic logic [W-1:0] b_in(int i, int j);
        return (i == 0) ? mmu_weights[j] : bp[(i > 0) ? i - 1 : 0][j];
    endfunction

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST || mmu_sync_rst) begin
            for (int i = 0; i < L; i++)
                for (int j = 0; j < L; j++) begin
                    acc[i][j] <= '0; ap[i][j] <= '0; bp[i][j] <= '0;
                end
        end else if (mmu_en) begin
            for (int i = 0; i < L; i++)
                for (int j = 0; j < L; j++) begin
                    acc[i][j] <= acc[i][j] + 32'(a_in(i, j)) * 32'(b_in(i, j));
                    ap[i][j]  <= a_in(i, j);
                    bp[i][j]  <= b_in(i, j);
                end
        end
    end

    int           ma [0:L-1][0:L-1] = '{'{4, 3, 7}, '{4, 4, 7}, '{6, 8, 2}};
    int           mb [0:L-1][0:L-1] = '{'{9, 4, 5}, '{10, 4, 5}, '{7, 4, 7}};
    logic [W-1:0] sa [0:L-1][0:L-1];
    logic [W-1:0] sb [0:L-1][0:L-1];
    int           exp_res [0:L-1][0:L-1];
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] obs_q[$];
    int  checks = 0;
    int  passed = 0;
    bit  inj_ready, inj_busy;

    function automatic logic [VW-1:0] pack_lanes();
        logic [VW-1:0] v;
        for (int r = 0; r < L; r++) begin
            v[r*W +: W]     = mmu_inputs[r];
            v[(L+r)*W +: W] = mmu_weights[r];
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] mk(int i0, int i1, int i2, int w0, int w1, int w2);
        logic [VW-1:0] v;
        v = {W'(w2), W'(w1), W'(w0), W'(i2), W'(i1), W'(i0)};
        return v;
    endfunction

    task automatic clear_shadow();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                sa[i][j] = '0; sb[i][j] = '0; exp_res[i][j] = 0;
            end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic load_elem(input bit sel, input int r, input int c, input int d);
        @(negedge CLK);
        load_en = 1'b1; load_sel = sel; load_row = 2'(r); load_col = 2'(c); load_data = W'(d);
        @(posedge CLK); #1;
        load_en = 1'b0;
        if (sel) sb[r][c] = W'(d); else sa[r][c] = W'(d);
    endtask

    task automatic load_all(input bit skip_a00);
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                if (!(skip_a00 && i == 0 && j == 0)) load_elem(1'b0, i, j, ma[i][j]);
                load_elem(1'b1, i, j, mb[i][j]);
            end
    endtask

    task automatic push_expected();
        logic [VW-1:0] v;
        for (int c = 1; c <= 2 * L - 1; c++) begin
            v = '0;
            for (int r = 0; r < L; r++) begin
                int k = c - r - 1;
                if (k >= 0 && k < L) begin
                    v[r*W +: W]     = sa[r][k];
                    v[(L+r)*W +: W] = sb[k][r];
                end
            end
            exp_q.push_back(v);
        end
        for (int d = 0; d < L; d++) exp_q.push_back('0);
    endtask

    task automatic do_run(input int limit, input bit with_load, input int ld, input int inject_k,
                          output bit got_done, output int done_k, output bit done_after,
                          output int sync_cnt);
        @(negedge CLK);
        start = 1'b1;
        if (with_load) begin
            load_en = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_col = 2'd0; load_data = W'(ld);
            sa[0][0] = W'(ld);
        end
        push_expected();
        @(posedge CLK); #1;
        start = 1'b0; load_en = 1'b0;
        got_done = 1'b0; done_k = -1; done_after = 1'b0; sync_cnt = 0;
        for (int k = 0; k <= limit; k++) begin
            if (k > 0) begin @(posedge CLK); #1; end
            if (k == inject_k + 1) begin start = 1'b0; load_en = 1'b0; end
            if (mmu_sync_rst) sync_cnt++;
            if (mmu_en) obs_q.push_back(pack_lanes());
            if (k == inject_k) begin
                inj_ready = load_ready; inj_busy = busy;
                start = 1'b1; load_en = 1'b1; load_sel = 1'b0;
                load_row = 2'd0; load_col = 2'd0; load_data = W'(99);
            end
            if (done) begin
                got_done = 1'b1; done_k = k;
                @(posedge CLK); #1;
                done_after = done;
                break;
            end
        end
        start = 1'b0; load_en = 1'b0;
        if (got_done)
            for (int i = 0; i < L; i++)
                for (int j = 0; j < L; j++) begin
                    int s = 0;
                    for (int k = 0; k < L; k++) s += int'(sa[i][k]) * int'(sb[k][j]);
                    exp_res[i][j] = (AUTO ? 0 : exp_res[i][j]) + s;
                end
    endtask

    task automatic test_reset();
        ASYNC_RST = 1'b0; start = 1'b0; load_en = 1'b0; load_sel = 1'b0;
        load_row = '0; load_col = '0; load_data = '0;
        clear_shadow();
        repeat (2) @(posedge CLK);
        @(negedge CLK); ASYNC_RST = 1'b1; #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else passed++;
        checks++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got=%b want=1", load_ready); else passed++;
        checks++; if (mmu_en !== 1'b0) $display("FAIL reset_mmu_en got=%b want=0", mmu_en); else passed++;
        checks++; if (mmu_sync_rst !== 1'b0) $display("FAIL reset_sync_rst got=%b want=0", mmu_sync_rst); else passed++;
        checks++; if (pack_lanes() !== '0) $display("FAIL reset_lanes got=%h want=0", pack_lanes()); else passed++;
    endtask

    task automatic test_feed_pattern();
        bit g, da; int dk, sc;
        load_all(1'b1);
        do_run(40, 1'b1, ma[0][0], -1, g, dk, da, sc);
        checks++; if (g !== 1'b1) $display("FAIL feed_done_seen got=%b want=1", g); else passed++;
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL feed_en_cycles got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
        if (obs_q.size() >= 5) begin
            checks++; if (obs_q[0] !== mk(4, 0, 0, 9, 0, 0)) $display("FAIL feed_step1 got=%h want=%h", obs_q[0], mk(4, 0, 0, 9, 0, 0)); else passed++;
            checks++; if (obs_q[2] !== mk(7, 4, 6, 7, 4, 5)) $display("FAIL feed_step3 got=%h want=%h", obs_q[2], mk(7, 4, 6, 7, 4, 5)); else passed++;
            checks++; if (obs_q[4] !== mk(0, 0, 2, 0, 0, 7)) $display("FAIL feed_step5 got=%h want=%h", obs_q[4], mk(0, 0, 2, 0, 0, 7)); else passed++;
        end else begin
            checks++; $display("FAIL feed_steps got=%0d lane cycles want>=5", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [VW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL feed_scoreboard got=%h want=%h", o, e); else passed++;
        end
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                checks++;
                if (acc[i][j] !== 32'(exp_res[i][j])) $display("FAIL feed_result[%0d][%0d] got=%0d want=%0d", i, j, acc[i][j], exp_res[i][j]);
                else passed++;
            end
    endtask

    task automatic test_timing();
        bit g, da; int dk, sc;
        do_run(40, 1'b0, 0, -1, g, dk, da, sc);
        checks++; if (dk != (AUTO ? 3 * L : 3 * L - 1)) $display("FAIL timing_done_cycle got=%0d want=%0d", dk, AUTO ? 3 * L : 3 * L - 1); else passed++;
        checks++; if (da !== 1'b0) $display("FAIL timing_done_width got=%b want=0", da); else passed++;
        checks++; if (sc != (AUTO ? 1 : 0)) $display("FAIL timing_sync_cycles got=%0d want=%0d", sc, AUTO ? 1 : 0); else passed++;
        checks++; if (load_ready !== 1'b1 || busy !== 1'b0) $display("FAIL timing_idle_after got=%b%b want=10", load_ready, busy); else passed++;
        checks++; if (acc[0][0] !== 32'(exp_res[0][0])) $display("FAIL timing_result00 got=%0d want=%0d", acc[0][0], exp_res[0][0]); else passed++;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_busy_ignore();
        bit g, da; int dk, sc;
        do_run(40, 1'b0, 0, 3, g, dk, da, sc);
        checks++; if (inj_ready !== 1'b0 || inj_busy !== 1'b1) $display("FAIL busy_flags got=%b%b want=01", inj_ready, inj_busy); else passed++;
        checks++; if (dk != (AUTO ? 3 * L : 3 * L - 1)) $display("FAIL busy_no_restart got=%0d want=%0d", dk, AUTO ? 3 * L : 3 * L - 1); else passed++;
        checks++; if (obs_q.size() != exp_q.size()) $display("FAIL busy_en_cycles got=%0d want=%0d", obs_q.size(), exp_q.size()); else passed++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [VW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL busy_scoreboard got=%h want=%h", o, e); else passed++;
        end
        exp_q.delete(); obs_q.delete();
        // A further run confirms the dropped write never reached the A buffer.
        do_run(40, 1'b0, 0, -1, g, dk, da, sc);
        checks++; if (obs_q.size() < 1 || obs_q[0] !== mk(4, 0, 0, 9, 0, 0)) $display("FAIL busy_buffer_kept got=%h want=%h", (obs_q.size() > 0) ? obs_q[0] : '0, mk(4, 0, 0, 9, 0, 0)); else passed++;
        for (int j = 0; j < L; j++) begin
            checks++;
            if (acc[0][j] !== 32'(exp_res[0][j])) $display("FAIL busy_result[0][%0d] got=%0d want=%0d", j, acc[0][j], exp_res[0][j]);
            else passed++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_abort_reset();
        bit g, da, seen; int dk, sc;
        do_run(7, 1'b0, 0, -1, g, dk, da, sc);
        checks++; if (g !== 1'b0 || mmu_en !== 1'b1) $display("FAIL abort_in_drain got=%b%b want=01", g, mmu_en); else passed++;
        #1 ASYNC_RST = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mmu_en !== 1'b0 || done !== 1'b0) $display("FAIL abort_outputs got=%b%b%b want=000", busy, mmu_en, done); else passed++;
        checks++; if (pack_lanes() !== '0) $display("FAIL abort_lanes got=%h want=0", pack_lanes()); else passed++;
        clear_shadow();
        @(negedge CLK); ASYNC_RST = 1'b1;
        seen = 1'b0;
        repeat (12) begin @(posedge CLK); #1; if (done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) $display("FAIL abort_no_done got=%b want=0", seen); else passed++;
        checks++; if (load_ready !== 1'b1) $display("FAIL abort_load_ready got=%b want=1", load_ready); else passed++;
        do_run(40, 1'b0, 0, -1, g, dk, da, sc);
        seen = 1'b0;
        foreach (obs_q[i]) if (obs_q[i] !== '0) seen = 1'b1;
        checks++; if (seen !== 1'b0 || obs_q.size() != 3 * L - 1) $display("FAIL abort_buffers_cleared got=%b/%0d want=0/%0d", seen, obs_q.size(), 3 * L - 1); else passed++;
        exp_q.delete(); obs_q.delete();
        load_all(1'b0);
        do_run(40, 1'b0, 0, -1, g, dk, da, sc);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [VW-1:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) $display("FAIL abort_rerun_lanes got=%h want=%h", o, e); else passed++;
        end
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < L; i++) begin
            checks++;
            if (acc[i][i] !== 32'(exp_res[i][i])) $display("FAIL abort_rerun_result[%0d][%0d] got=%0d want=%0d", i, i, acc[i][i], exp_res[i][i]);
            else passed++;
        end
    endtask

    task automatic test_rerun_accumulate();
        bit g, da; int dk, sc;
        @(negedge CLK); ASYNC_RST = 1'b0;
        clear_shadow();
        @(negedge CLK); ASYNC_RST = 1'b1;
        load_all(1'b0);
        do_run(40, 1'b0, 0, -1, g, dk, da, sc);
        do_run(40, 1'b0, 0, -1, g, dk, da, sc);
        exp_q.delete(); obs_q.delete();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < L; j++) begin
                int s = 0;
                for (int k = 0; k < L; k++) s += ma[i][k] * mb[k][j];
                s = AUTO ? s : 2 * s;
                checks++;
                if (acc[i][j] !== 32'(s)) $display("FAIL rerun_result[%0d][%0d] got=%0d want=%0d", i, j, acc[i][j], s);
                else passed++;
            end
    endtask

    initial begin
        test_reset();
        test_feed_pattern();
        test_timing();
        test_busy_ignore();
        test_abort_reset();
        test_rerun_accumulate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
